inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Producer side of the fetch->decode interface: holds the PC, fetches 32-bit words via the memory
//  controller, and delivers one-cycle inst_done/inst/inst_pc pulses to the decoder. Sequential PC
//  (pc+4); redirect only on ROB rollback. Back-pressure via stall (RS/LSB/ROB full).
// PARAMETERS
//  RESET_PC       32'h0   PC loaded on reset
//  ICACHE_IDX_W   6       icache index bits (2**N one-word lines); used only with IFETCH_ICACHE_EN
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  rdy          in   1   global ready; low = freeze all state
//  rollback     in   1   ROB misprediction flush
//  rollback_pc  in   32  redirect target, valid with rollback
//  stall        in   1   downstream cannot accept an instruction this cycle
//  inst_done    out  1   one-cycle pulse: inst/inst_pc valid
//  inst         out  32  fetched instruction
//  inst_pc      out  32  address of inst
//  mem_req      out  1   fetch request to memory controller, level, held until mem_done
//  mem_addr     out  32  fetch address, stable while mem_req high
//  mem_done     in   1   one-cycle pulse: mem_data valid for the outstanding request
//  mem_data     in   32  fetched word (little-endian)
// BEHAVIOUR
//  Reset (rst=1 on clk edge): pc=RESET_PC, state=IDLE, inst_done=0, inst=0, inst_pc=0, mem_req=0,
//   mem_addr=0; icache valid bits all cleared. rst overrides rdy and rollback.
//  rdy=0: every register holds; inst_done forced 0 that cycle; mem_done ignored (mem ctrl is frozen too).
//  FSM states: IDLE, WAIT, DISCARD.
//   IDLE: if rollback -> pc=rollback_pc, stay. Else if !stall -> mem_req=1, mem_addr=pc, go WAIT.
//     stall=1 -> no request, nothing emitted.
//   WAIT: mem_req/mem_addr held. On mem_done (no rollback): inst=mem_data, inst_pc=mem_addr,
//     inst_done=1 next cycle, pc+=4, mem_req=0, go IDLE. New request earliest the cycle after.
//     stall does not cancel an in-flight request; result is still delivered (decoder stall is
//     sampled one cycle before issue, so one in-flight slot is guaranteed by downstream).
//   WAIT + rollback: pc=rollback_pc, mem_req=0; if mem_done same cycle -> data dropped, go IDLE;
//     else go DISCARD.
//   DISCARD: mem_req=0; wait for mem_done, drop data, go IDLE. Rollback here: pc=rollback_pc, stay.
//  Rollback in any state suppresses inst_done for the following cycle (no wrong-path pulse).
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0; pc[1:0] always 0 (rollback_pc[1:0] ignored).
//  Latency (miss/no cache): request in cycle t, mem_done at t+k -> inst_done at t+k+1.
// CONFIGURATION
//  IFETCH_ICACHE_EN defined: direct-mapped icache, 2**ICACHE_IDX_W lines, one word each;
//   index=pc[ICACHE_IDX_W+1:2], tag=pc[31:ICACHE_IDX_W+2]. IDLE, !stall, !rollback, hit ->
//   inst_done next cycle with cached word, pc+=4, no mem_req (1 inst/cycle sustained on hits).
//   Miss -> normal WAIT path; accepted mem_done fills line (valid=1). Discarded data never fills.
//   No invalidation except reset.
//  Not defined: no cache storage, every fetch goes to memory; ICACHE_IDX_W unused.
// STRUCTURE
//  Shared defs (def.v): `INST_WID, `ADDR_WID, fetch FSM state encodings, RESET_PC default.
//  One sub-module: icache_dm (tag/data/valid arrays, combinational lookup, sync fill port),
//   instantiated only under IFETCH_ICACHE_EN.
// TESTING
//  1 Reset, RESET_PC=0, mem responds after 3 cycles with 32'h00000513 -> mem_addr=0, inst_done
//    one cycle after mem_done, inst=32'h00000513, inst_pc=0; next mem_addr=4.
//  2 stall=1 held 5 cycles in IDLE -> mem_req stays 0, inst_done stays 0; release -> request at pc.
//  3 Rollback to 32'h100 during WAIT (addr 8), mem_done 2 cycles later -> data dropped, no
//    inst_done, next mem_addr=32'h100.
//  4 Rollback coincident with mem_done -> no inst_done, next request at rollback_pc, no DISCARD.
//  5 rdy=0 for 3 cycles mid-WAIT -> mem_req/mem_addr/pc unchanged, inst_done 0; resumes cleanly.
//  6 IFETCH_ICACHE_EN: loop 0x0..0xC fetched twice -> 2nd pass four inst_done pulses in 4
//    consecutive cycles, zero mem_req; rollback_pc=0xFFFF_FFFC -> next pc wraps to 0.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-unit definitions: datapath widths, default reset PC, fetch FSM encodings.
package inst_fetcher_pkg;

    localparam int INST_WID = 32;
    localparam int ADDR_WID = 32;

    localparam logic [ADDR_WID-1:0] DEF_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    // Instruction addresses are always word aligned; low bits of any target are dropped.
    function automatic logic [ADDR_WID-1:0] alignPc(input logic [ADDR_WID-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
// Only the valid bits are reset; tag/data contents are meaningless until their line is filled.
module icache_dm
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_WID-1:0] i_lookupAddr,
    output logic                o_hit,
    output logic [INST_WID-1:0] o_data,
    input  logic                i_fillEn,
    input  logic [ADDR_WID-1:0] i_fillAddr,
    input  logic [INST_WID-1:0] i_fillData
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_WID - IDX_W - 2;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [INST_WID-1:0] r_data [LINES];

    logic [IDX_W-1:0] w_lookupIdx;
    logic [TAG_W-1:0] w_lookupTag;
    logic [IDX_W-1:0] w_fillIdx;
    logic [TAG_W-1:0] w_fillTag;
    logic             w_unusedLowBits;

    assign w_lookupIdx     = i_lookupAddr[IDX_W+1:2];
    assign w_lookupTag     = i_lookupAddr[ADDR_WID-1:IDX_W+2];
    assign w_fillIdx       = i_fillAddr[IDX_W+1:2];
    assign w_fillTag       = i_fillAddr[ADDR_WID-1:IDX_W+2];
    assign w_unusedLowBits = ^{i_lookupAddr[1:0], i_fillAddr[1:0]};

    assign o_hit  = r_valid[w_lookupIdx] && (r_tag[w_lookupIdx] == w_lookupTag);
    assign o_data = r_data[w_lookupIdx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_fillEn) begin
            r_valid[w_fillIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fillEn) begin
            r_tag[w_fillIdx]  <= w_fillTag;
            r_data[w_fillIdx] <= i_fillData;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch unit: owns the PC, issues word fetches to the memory controller and pulses results to decode.
// Define IFETCH_ICACHE_EN to add a direct-mapped icache (icache_dm) in front of memory.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [ADDR_WID-1:0] RESET_PC     = DEF_RESET_PC,
    parameter int                  ICACHE_IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic [ADDR_WID-1:0] rollback_pc,
    input  logic                stall,
    output logic                inst_done,
    output logic [INST_WID-1:0] inst,
    output logic [ADDR_WID-1:0] inst_pc,
    output logic                mem_req,
    output logic [ADDR_WID-1:0] mem_addr,
    input  logic                mem_done,
    input  logic [INST_WID-1:0] mem_data
);

    logic [1:0]          r_state;
    logic [ADDR_WID-1:0] r_pc;
    logic                r_instDone;
    logic [INST_WID-1:0] r_inst;
    logic [ADDR_WID-1:0] r_instPc;
    logic                r_memReq;
    logic [ADDR_WID-1:0] r_memAddr;

    logic                w_cacheHit;
    logic [INST_WID-1:0] w_cacheData;

`ifdef IFETCH_ICACHE_EN
    logic w_fillEn;

    // Only responses that are actually delivered to decode may populate the cache.
    assign w_fillEn = rdy && (r_state == S_WAIT) && mem_done && !rollback;

    icache_dm #(
        .IDX_W(ICACHE_IDX_W)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .i_lookupAddr(r_pc),
        .o_hit       (w_cacheHit),
        .o_data      (w_cacheData),
        .i_fillEn    (w_fillEn),
        .i_fillAddr  (r_memAddr),
        .i_fillData  (mem_data)
    );
`else
    logic w_unusedCfg;

    assign w_cacheHit  = 1'b0;
    assign w_cacheData = '0;
    assign w_unusedCfg = (ICACHE_IDX_W != 0);
`endif

    // The pulse register is held while frozen, so it is masked rather than cleared to avoid losing it.
    assign inst_done = r_instDone & rdy;
    assign inst      = r_inst;
    assign inst_pc   = r_instPc;
    assign mem_req   = r_memReq;
    assign mem_addr  = r_memAddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instDone <= 1'b0;
            r_inst     <= '0;
            r_instPc   <= '0;
            r_memReq   <= 1'b0;
            r_memAddr  <= '0;
        end else if (rdy) begin
            r_instDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rollback) begin
                        r_pc <= alignPc(rollback_pc);
                    end else if (!stall) begin
                        if (w_cacheHit) begin
                            r_inst     <= w_cacheData;
                            r_instPc   <= r_pc;
                            r_instDone <= 1'b1;
                            r_pc       <= r_pc + 32'd4;
                        end else begin
                            r_memReq  <= 1'b1;
                            r_memAddr <= r_pc;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                // A flush with no response yet must still absorb the stale mem_done in DISCARD.
                S_WAIT: begin
                    if (rollback) begin
                        r_pc     <= alignPc(rollback_pc);
                        r_memReq <= 1'b0;
                        r_state  <= mem_done ? S_IDLE : S_DISCARD;
                    end else if (mem_done) begin
                        r_inst     <= mem_data;
                        r_instPc   <= r_memAddr;
                        r_instDone <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                        r_memReq   <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    r_memReq <= 1'b0;
                    if (rollback) begin
                        r_pc <= alignPc(rollback_pc);
                    end
                    if (mem_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_memReq <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed, table-driven bench for inst_fetcher; the cached-loop sequence runs when IFETCH_ICACHE_EN is set.
module tb_inst_fetcher;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        stall;
    logic        inst_done;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int nCompared;
    int nMismatched;

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        rollback;
        logic [31:0] rbPc;
        logic        memDone;
        logic [31:0] memData;
        logic        expDone;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInst;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    inst_fetcher dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .rollback_pc(rollback_pc),
        .stall      (stall),
        .inst_done  (inst_done),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents used by the cached-loop sequence; address 0 matches the table's data.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h0000_0513 + (addr << 8);
    endfunction

    function automatic vec_t mkVec(input logic r, input logic s, input logic rb, input logic [31:0] rbPc,
                                   input logic md, input logic [31:0] mdata, input logic eDone,
                                   input logic eReq, input logic [31:0] eAddr, input logic [31:0] eInst,
                                   input logic [31:0] ePc);
        vec_t v;
        v.rdy = r; v.stall = s; v.rollback = rb; v.rbPc = rbPc; v.memDone = md; v.memData = mdata;
        v.expDone = eDone; v.expReq = eReq; v.expAddr = eAddr; v.expInst = eInst; v.expPc = ePc;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rdy         = v.rdy;
        stall       = v.stall;
        rollback    = v.rollback;
        rollback_pc = v.rbPc;
        mem_done    = v.memDone;
        mem_data    = v.memData;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkField($sformatf("v%0d.inst_done", idx), {31'b0, inst_done}, {31'b0, v.expDone});
        checkField($sformatf("v%0d.mem_req", idx), {31'b0, mem_req}, {31'b0, v.expReq});
        checkField($sformatf("v%0d.mem_addr", idx), mem_addr, v.expAddr);
        checkField($sformatf("v%0d.inst", idx), inst, v.expInst);
        checkField($sformatf("v%0d.inst_pc", idx), inst_pc, v.expPc);
    endtask

    localparam logic [31:0] I0 = 32'h0000_0513;
    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] I2 = 32'h0020_0113;
    localparam logic [31:0] I3 = 32'h0030_0193;
    localparam logic [31:0] I4 = 32'h0040_0213;
    localparam logic [31:0] WRAP = 32'hFFFF_FFFC;

    initial begin
        nCompared   = 0;
        nMismatched = 0;

        //              rdy st rb rbPc          md mdata         done req addr        inst pc
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h0,      0,  0));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h0,      0,  0));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h0,      0,  0));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I0,           1, 0, 32'h0,      I0, 32'h0));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h4,      I0, 32'h0));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I1,           1, 0, 32'h4,      I1, 32'h4));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkVec(1, 1, 0, 0,      0, 0,            0, 0, 32'h4,      I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h8,      I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 1, 32'h100,    0, 0,            0, 0, 32'h8,      I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 0, 32'h8,      I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, 32'hDEADBEEF, 0, 0, 32'h8,      I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h100,    I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 1, 32'h203,    1, 32'hCAFEBABE, 0, 0, 32'h100,    I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h200,    I1, 32'h4));
        vecs.push_back(mkVec(0, 0, 0, 0,          1, 32'h11111111, 0, 1, 32'h200,    I1, 32'h4));
        vecs.push_back(mkVec(0, 0, 1, 32'h40,     1, 32'h11111111, 0, 1, 32'h200,    I1, 32'h4));
        vecs.push_back(mkVec(0, 0, 0, 0,          1, 32'h11111111, 0, 1, 32'h200,    I1, 32'h4));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I2,           1, 0, 32'h200,    I2, 32'h200));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h204,    I2, 32'h200));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I3,           1, 0, 32'h204,    I3, 32'h204));
        vecs.push_back(mkVec(1, 0, 1, WRAP,       0, 0,            0, 0, 32'h204,    I3, 32'h204));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, WRAP,       I3, 32'h204));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I4,           1, 0, WRAP,       I4, WRAP));
        vecs.push_back(mkVec(1, 0, 0, 0,          0, 0,            0, 1, 32'h0,      I4, WRAP));
        vecs.push_back(mkVec(1, 0, 0, 0,          1, I0,           1, 0, 32'h0,      I0, 32'h0));

        // Reset is asserted with rdy low and a rollback pending: reset must still win.
        rst = 1'b1; rdy = 1'b0; rollback = 1'b1; rollback_pc = 32'h40;
        stall = 1'b0; mem_done = 1'b0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkField("reset.mem_req", {31'b0, mem_req}, 32'h0);
        checkField("reset.mem_addr", mem_addr, 32'h0);
        checkField("reset.inst", inst, 32'h0);
        checkField("reset.inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; stall = 1'b1;
        @(posedge clk);
        #1;
        checkField("reset.inst_done", {31'b0, inst_done}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

`ifdef IFETCH_ICACHE_EN
        begin
            int got;
            int cyc;
            @(negedge clk);
            rollback = 1'b1; rollback_pc = 32'h0; stall = 1'b0; mem_done = 1'b0;
            @(posedge clk);
            #1;
            checkField("loop.rb.inst_done", {31'b0, inst_done}, 32'h0);

            got = 0;
            cyc = 0;
            while (got < 4 && cyc < 40) begin
                @(negedge clk);
                rollback = 1'b0; stall = 1'b0;
                mem_done = mem_req;
                mem_data = memWord(mem_addr);
                @(posedge clk);
                #1;
                if (inst_done) begin
                    checkField($sformatf("pass1[%0d].inst_pc", got), inst_pc, 32'(got * 4));
                    checkField($sformatf("pass1[%0d].inst", got), inst, memWord(32'(got * 4)));
                    got++;
                end
                cyc++;
            end
            if (got < 4) checkField("pass1.timeout_fetches", 32'(got), 32'd4);

            @(negedge clk);
            rollback = 1'b1; rollback_pc = 32'h0; mem_done = 1'b0;
            @(posedge clk);
            #1;
            checkField("pass2.rb.inst_done", {31'b0, inst_done}, 32'h0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                rollback = 1'b0; stall = 1'b0;
                @(posedge clk);
                #1;
                checkField($sformatf("pass2[%0d].inst_done", i), {31'b0, inst_done}, 32'h1);
                checkField($sformatf("pass2[%0d].mem_req", i), {31'b0, mem_req}, 32'h0);
                checkField($sformatf("pass2[%0d].inst_pc", i), inst_pc, 32'(i * 4));
                checkField($sformatf("pass2[%0d].inst", i), inst, memWord(32'(i * 4)));
            end
        end
`endif

        // Reset in the middle of a fetch, then the first post-reset request must go to RESET_PC.
        @(negedge clk);
        rdy = 1'b1; stall = 1'b0; rollback = 1'b0; mem_done = 1'b0;
        @(posedge clk);
        #1;
        checkField("midreset.pre.mem_req", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1; rdy = 1'b0; rollback = 1'b1; rollback_pc = 32'h80;
        @(posedge clk);
        #1;
        checkField("midreset.mem_req", {31'b0, mem_req}, 32'h0);
        checkField("midreset.mem_addr", mem_addr, 32'h0);
        checkField("midreset.inst", inst, 32'h0);
        checkField("midreset.inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        checkField("postreset.mem_req", {31'b0, mem_req}, 32'h1);
        checkField("postreset.mem_addr", mem_addr, 32'h0);
        checkField("postreset.inst_done", {31'b0, inst_done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
